// File: rtl/scalar_wb_arbiter_if.sv
// Write-side bundle of the scalar write-back arbiter: the two producer
// handshakes and the register-file write port it drives.

`ifndef SCALAR_RF_NOP
`define SCALAR_RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

interface scalar_wb_arbiter_if #(
  parameter int LEN = 32
);
  logic           a_valid;
  logic [4:0]     a_rd;
  logic [LEN-1:0] a_data;
  logic           a_ready;

  logic           b_valid;
  logic [4:0]     b_rd;
  logic [LEN-1:0] b_data;
  logic           b_ready;

  logic [1:0]     rf_signal;
  logic [4:0]     rf_rd;
  logic [LEN-1:0] rf_data;
  logic           write_back_enabled;

  // Producers and register file side.
  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready,
    input  rf_signal, rf_rd, rf_data, write_back_enabled
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready,
    output rf_signal, rf_rd, rf_data, write_back_enabled
  );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file write-back arbiter with a per-register busy
// scoreboard. Requester A (scalar pipe) and B (vector-unit scalar results)
// share one write port through a registered output slot; round-robin on
// contention. Decode queries busy bits for RAW stalls.

`ifndef SCALAR_RF_NOP
`define SCALAR_RF_NOP 2'b00
`endif
`ifndef SCALAR_RF_WRITE
`define SCALAR_RF_WRITE 2'b01
`endif

module scalar_wb_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy_in,
  scalar_wb_arbiter_if.slave  bus,
  input  logic                busy_set_en,
  input  logic [4:0]          busy_set_rd,
  input  logic [4:0]          rs1_q,
  input  logic [4:0]          rs2_q,
  output logic                rs1_busy,
  output logic                rs2_busy
);

  // ADDR_WIDTH exists only for parameter uniformity across the core.
  logic unused_addr_width;
  assign unused_addr_width = ^ADDR_WIDTH;

  logic           rr;
  logic           slot_valid;
  logic [31:0]    busy_q;
  logic [31:0]    busy_next;

  logic           grant_a;
  logic           grant_b;
  logic [4:0]     win_rd;
  logic [LEN-1:0] win_data;

  // Grant selection: sole requester wins, otherwise rr picks (0=A, 1=B).
  always_comb begin
    grant_a  = bus.a_valid & (~bus.b_valid | ~rr);
    grant_b  = bus.b_valid & (~bus.a_valid |  rr);
    win_rd   = grant_b ? bus.b_rd   : bus.a_rd;
    win_data = grant_b ? bus.b_data : bus.a_data;
  end

  // Handshake outputs; held low in reset so producers never see a
  // spurious accept while the slot is being cleared.
  assign bus.a_ready = rst & rdy_in & grant_a;
  assign bus.b_ready = rst & rdy_in & grant_b;

  // Output slot and round-robin pointer; drains on every enabled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid  <= 1'b0;
      rr          <= 1'b0;
      bus.rf_rd   <= '0;
      bus.rf_data <= '0;
    end else if (rdy_in) begin
      if (grant_a | grant_b) begin
        // x0 writes are accepted but never presented to the file.
        slot_valid  <= (win_rd != 5'd0);
        bus.rf_rd   <= win_rd;
        bus.rf_data <= win_data;
        rr          <= grant_a;
      end else begin
        slot_valid  <= 1'b0;
      end
    end
  end

  assign bus.write_back_enabled = slot_valid;
  assign bus.rf_signal          = slot_valid ? `SCALAR_RF_WRITE : `SCALAR_RF_NOP;

  // Scoreboard next state: commit clears, then issue sets, so a fresh
  // producer for the same rd keeps the bit set.
  always_comb begin
    busy_next = busy_q;
    if (slot_valid)
      busy_next[bus.rf_rd] = 1'b0;
    if (busy_set_en && (busy_set_rd != 5'd0))
      busy_next[busy_set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register, frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy_q <= '0;
    else if (rdy_in)
      busy_q <= busy_next;
  end

  assign rs1_busy = busy_q[rs1_q];
  assign rs2_busy = busy_q[rs2_q];

endmodule
